// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge
//   Memory-side end of the data-memory port. Accepts one load/store per
//   instruction from EX and formats store byte lanes and strobes. It then runs
//   a two-phase handshake (addr_ok, then data_ok) to a multi-cycle data memory.
//   The pipeline is held through stallreq until the access completes. The raw
//   32-bit read word is returned; MEM does the byte/half extraction.
//
// Ports
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   cpu_en/wr/size     access request from EX (size 0=byte 1=half 2/3=word)
//   cpu_addr/wdata     byte address and right-aligned store data
//   cpu_flush          cancel the current instruction
//   stallreq           hold pipeline stages up to EX
//   cpu_rdata          raw read word of the last completed load
//   cpu_rdata_valid    one-cycle pulse when an access finishes
//   addr_err           one-cycle pulse with rdata_valid for a misaligned access
//   mem_req/wr/size    request to memory, held until mem_addr_ok
//   mem_addr           unmodified byte address
//   mem_wstrb/wdata    byte-lane strobes and lane-replicated store data
//   mem_addr_ok        request accepted this cycle
//   mem_data_ok        read data valid / write complete this cycle
//   mem_rdata          read data from memory
module data_sram_like_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_en,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_flush,
  output logic                  stallreq,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rdata_valid,
  output logic                  addr_err,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic                  cancel;
  logic                  misaligned;
  logic [3:0]            wstrb_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  // Store formatting and alignment check on the incoming request. Size 3 is
  // handled like a word. Loads never drive strobes.
  always_comb begin
    misaligned = 1'b0;
    wstrb_next = 4'b0000;
    wdata_next = cpu_wdata;
    case (cpu_size)
      2'd0: begin
        wstrb_next = 4'b0001 << cpu_addr[1:0];
        wdata_next = {4{cpu_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = cpu_addr[0];
        wstrb_next = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{cpu_wdata[15:0]}};
      end
      default: begin
        misaligned = (cpu_addr[1:0] != 2'b00);
        wstrb_next = 4'b1111;
      end
    endcase
    if (!cpu_wr) wstrb_next = 4'b0000;
  end

  // Stall is gated by resetn so that a mid-transaction reset releases the
  // pipeline immediately, even while EX still presents cpu_en.
  assign stallreq = resetn &
                    (((state == IDLE) & cpu_en & ~cpu_flush) |
                     (state == REQ) | (state == WAIT));

  // Handshake FSM. The mem_* request registers are loaded once in IDLE and
  // stay stable through REQ. A flush during REQ/WAIT only marks the access as
  // cancelled: the issued transaction still has to drain on data_ok, because
  // the memory cannot take a request back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cancel          <= 1'b0;
      cpu_rdata       <= '0;
      cpu_rdata_valid <= 1'b0;
      addr_err        <= 1'b0;
      mem_req         <= 1'b0;
      mem_wr          <= 1'b0;
      mem_size        <= 2'd0;
      mem_addr        <= '0;
      mem_wstrb       <= 4'b0000;
      mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_rdata_valid <= 1'b0;
          addr_err        <= 1'b0;
          cancel          <= 1'b0;
          if (cpu_en && !cpu_flush) begin
            mem_wr    <= cpu_wr;
            mem_size  <= cpu_size;
            mem_addr  <= cpu_addr;
            mem_wstrb <= wstrb_next;
            mem_wdata <= wdata_next;
            if (misaligned) begin
              cpu_rdata_valid <= 1'b1;
              addr_err        <= 1'b1;
              state           <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (cpu_flush) cancel <= 1'b1;
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_data_ok) begin
            if (cancel || cpu_flush) begin
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              if (!mem_wr) cpu_rdata <= mem_rdata;
              cpu_rdata_valid <= 1'b1;
              state           <= DONE;
            end
          end else if (cpu_flush) begin
            cancel <= 1'b1;
          end
        end
        DONE: begin
          cpu_rdata_valid <= 1'b0;
          addr_err        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
